// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // Value placed on the shared memory bus when this unit is not driving it.
    localparam logic [DATA_W-1:0] BUS_IDLE = {DATA_W{1'bz}};

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCapt,
        StPresent,
        StLoad
    } state_e;

endpackage

// File: rtl/fetch_load_port.sv
// Loader write port: registers the loader address/data and owns the tristate bus driver.
// Only used when INSTR_FETCH_LOADER_EN is defined.
module fetch_load_port
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              drive_o,
    inout  wire  [DATA_W-1:0] mem_data_io
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              drive_q;

    // Capture the write when the FSM enters LOAD; drive enable lasts exactly that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            drive_q <= 1'b0;
        end else begin
            drive_q <= load_i;
            if (load_i) begin
                addr_q <= ld_addr_i;
                data_q <= ld_data_i;
            end
        end
    end

    assign mem_data_io = drive_q ? data_q : BUS_IDLE;
    assign addr_o      = addr_q;
    assign drive_o     = drive_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the 8-bit instruction memory and hands bytes
// to decode over valid/ready. Optional loader path enabled by INSTR_FETCH_LOADER_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic              mem_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    inout  wire  [DATA_W-1:0] mem_data_io
`ifdef INSTR_FETCH_LOADER_EN
    ,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              cs_q, cs_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fetch_d, load_d;
    logic              load_req;

`ifdef INSTR_FETCH_LOADER_EN
    assign load_req = ld_valid_i;
`else
    assign load_req = 1'b0;
`endif

    // Next-state, PC and capture logic; redirect takes priority over sequential advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        unique case (state_q)
            StIdle: begin
                if (br_valid_i) pc_d = br_target_i;
                if (load_req) begin
                    state_d = StLoad;
                end else if (!halt_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (br_valid_i) begin
                    pc_d    = br_target_i;
                    state_d = StReq;
                end else begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                if (br_valid_i) begin
                    pc_d    = br_target_i;
                    state_d = StReq;
                end else begin
                    instr_d    = mem_data_io;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = StPresent;
                end
            end
            StPresent: begin
                if (br_valid_i) begin
                    // Squash the presented byte even if decode is ready this cycle.
                    valid_d = 1'b0;
                    pc_d    = br_target_i;
                    state_d = StReq;
                end else if (instr_ready_i) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + 8'd1;
                    state_d = halt_i ? StIdle : StReq;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Memory controls are decoded from the next state so they are registered with it.
    always_comb begin
        fetch_d = (state_d == StReq) || (state_d == StCapt);
        load_d  = (state_d == StLoad);
        cs_d    = fetch_d || load_d;
        oe_d    = fetch_d;
        addr_d  = fetch_d ? pc_d : addr_q;
    end

    // State, PC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            cs_q       <= 1'b0;
            oe_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            cs_q       <= cs_d;
            oe_q       <= oe_d;
            addr_q     <= addr_d;
        end
    end

    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign mem_cs_o      = cs_q;
    assign mem_oe_o      = oe_q;

`ifdef INSTR_FETCH_LOADER_EN
    logic [ADDR_W-1:0] ld_addr_q;
    logic              ld_drive;

    fetch_load_port u_load_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_d),
        .ld_addr_i  (ld_addr_i),
        .ld_data_i  (ld_data_i),
        .addr_o     (ld_addr_q),
        .drive_o    (ld_drive),
        .mem_data_io(mem_data_io)
    );

    assign mem_we_o   = ld_drive;
    assign ld_ready_o = ld_drive;
    assign mem_addr_o = ld_drive ? ld_addr_q : addr_q;
`else
    assign mem_we_o    = 1'b0;
    assign mem_addr_o  = addr_q;
    assign mem_data_io = BUS_IDLE;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected fetched bytes.
// Loader steps are included when INSTR_FETCH_LOADER_EN is defined.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       halt, br_valid, instr_ready;
    logic [7:0] br_target;
    logic [7:0] instr, instr_pc, mem_addr;
    logic       instr_valid, mem_cs, mem_we, mem_oe;
    wire  [7:0] mem_data;
`ifdef INSTR_FETCH_LOADER_EN
    logic       ld_valid, ld_ready;
    logic [7:0] ld_addr, ld_data;
`endif

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] pc;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(8'h10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt_i       (halt),
        .br_valid_i   (br_valid),
        .br_target_i  (br_target),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .mem_cs_o     (mem_cs),
        .mem_we_o     (mem_we),
        .mem_oe_o     (mem_oe),
        .mem_addr_o   (mem_addr),
        .mem_data_io  (mem_data)
`ifdef INSTR_FETCH_LOADER_EN
        ,
        .ld_valid_i   (ld_valid),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .ld_ready_o   (ld_ready)
`endif
    );

    // Memory model: asynchronous read onto the bus, synchronous write from the bus.
    assign mem_data = (mem_cs && mem_oe) ? mem[mem_addr] : 8'hzz;

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= mem_data;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem[pc];
        sb.push_back(e);
    endtask

    // Wait (bounded) for a presented byte and compare it with the scoreboard head.
    task automatic wait_fetch(input string tag);
        exp_t e;
        int   n = 0;
        while (!instr_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {7'd0, instr_valid}, 8'h01);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h00, 8'h01);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, instr, e.data);
            chk({tag, "_pc"}, instr_pc, e.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'hA5;

        rst_n       = 1'b0;
        halt        = 1'b1;
        br_valid    = 1'b0;
        br_target   = 8'h00;
        instr_ready = 1'b0;
`ifdef INSTR_FETCH_LOADER_EN
        ld_valid = 1'b0;
        ld_addr  = 8'h00;
        ld_data  = 8'h00;
`endif
        #1;
        chk("rst_instr", instr, 8'h00);
        chk("rst_instr_pc", instr_pc, 8'h00);
        chk("rst_valid", {7'd0, instr_valid}, 8'h00);
        chk("rst_cs", {7'd0, mem_cs}, 8'h00);
        chk("rst_we", {7'd0, mem_we}, 8'h00);
        chk("rst_oe", {7'd0, mem_oe}, 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
`ifdef INSTR_FETCH_LOADER_EN
        chk("rst_ld_ready", {7'd0, ld_ready}, 8'h00);
`endif

        tick();
        rst_n = 1'b1;
        tick();
        chk("halted_cs", {7'd0, mem_cs}, 8'h00);

        // First fetch from RESET_PC, decode stalled.
        halt = 1'b0;
        push(8'h10);
        tick();
        chk("req_cs", {7'd0, mem_cs}, 8'h01);
        chk("req_oe", {7'd0, mem_oe}, 8'h01);
        chk("req_we", {7'd0, mem_we}, 8'h00);
        chk("req_addr", mem_addr, 8'h10);
        tick();
        chk("capt_valid", {7'd0, instr_valid}, 8'h00);
        chk("capt_cs", {7'd0, mem_cs}, 8'h01);
        tick();
        chk("present_cs", {7'd0, mem_cs}, 8'h00);
        wait_fetch("first");

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {7'd0, instr_valid}, 8'h01);
            chk("stall_instr", instr, 8'hA5);
            chk("stall_cs", {7'd0, mem_cs}, 8'h00);
        end

        // Accept; next request at PC+1.
        instr_ready = 1'b1;
        tick();
        chk("next_valid", {7'd0, instr_valid}, 8'h00);
        chk("next_addr", mem_addr, 8'h11);
        push(8'h11);
        wait_fetch("second");

        // Redirect during CAPT: the byte at 0x12 is never presented.
        tick();
        chk("r_req_addr", mem_addr, 8'h12);
        tick();
        br_valid  = 1'b1;
        br_target = 8'h40;
        push(8'h40);
        tick();
        br_valid = 1'b0;
        chk("redir_valid", {7'd0, instr_valid}, 8'h00);
        chk("redir_addr", mem_addr, 8'h40);
        tick();
        chk("redir_capt_valid", {7'd0, instr_valid}, 8'h00);
        wait_fetch("redirect");

        // Redirect while presenting with ready high squashes the byte.
        br_valid  = 1'b1;
        br_target = 8'hFF;
        push(8'hFF);
        tick();
        br_valid = 1'b0;
        chk("squash_valid", {7'd0, instr_valid}, 8'h00);
        chk("squash_addr", mem_addr, 8'hFF);
        wait_fetch("pc_ff");

        // PC wraps from 0xFF to 0x00; halt during the fetch still hands the byte off.
        tick();
        chk("wrap_addr", mem_addr, 8'h00);
        push(8'h00);
        halt = 1'b1;
        wait_fetch("wrap");
        tick();
        chk("halt_cs", {7'd0, mem_cs}, 8'h00);
        chk("halt_valid", {7'd0, instr_valid}, 8'h00);
        tick();
        chk("halt_idle_cs", {7'd0, mem_cs}, 8'h00);

`ifdef INSTR_FETCH_LOADER_EN
        // Two loader writes while halted, then fetch them back from PC 0x00.
        ld_valid = 1'b1;
        ld_addr  = 8'h00;
        ld_data  = 8'h3C;
        tick();
        chk("ld0_we", {7'd0, mem_we}, 8'h01);
        chk("ld0_oe", {7'd0, mem_oe}, 8'h00);
        chk("ld0_cs", {7'd0, mem_cs}, 8'h01);
        chk("ld0_addr", mem_addr, 8'h00);
        chk("ld0_ready", {7'd0, ld_ready}, 8'h01);
        ld_addr = 8'h01;
        ld_data = 8'h7E;
        tick();
        chk("ld_gap_we", {7'd0, mem_we}, 8'h00);
        chk("ld_gap_ready", {7'd0, ld_ready}, 8'h00);
        tick();
        chk("ld1_we", {7'd0, mem_we}, 8'h01);
        chk("ld1_addr", mem_addr, 8'h01);
        ld_valid = 1'b0;
        tick();
        chk("ld_done_we", {7'd0, mem_we}, 8'h00);
        br_valid  = 1'b1;
        br_target = 8'h00;
        tick();
        br_valid = 1'b0;
        halt     = 1'b0;
        sb.push_back('{pc: 8'h00, data: 8'h3C});
        sb.push_back('{pc: 8'h01, data: 8'h7E});
        tick();
        chk("ldf_we", {7'd0, mem_we}, 8'h00);
        wait_fetch("ld_fetch0");
        tick();
        wait_fetch("ld_fetch1");
        halt = 1'b1;
        tick();
        tick();
`endif

        // Asynchronous reset in the middle of a request.
        halt = 1'b0;
        tick();
        chk("pre_rst_cs", {7'd0, mem_cs}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", {7'd0, mem_cs}, 8'h00);
        chk("arst_oe", {7'd0, mem_oe}, 8'h00);
        chk("arst_addr", mem_addr, 8'h00);
        chk("arst_valid", {7'd0, instr_valid}, 8'h00);
        chk("arst_instr", instr, 8'h00);
        chk("arst_instr_pc", instr_pc, 8'h00);
        tick();
        rst_n = 1'b1;
        push(8'h10);
        tick();
        chk("restart_addr", mem_addr, 8'h10);
        wait_fetch("restart");
        halt = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
